// File: rtl/pc_sequencer_if.sv
// Bundles the sequencer's program-counter, ROM/ALU and status signals into one port.
// master = sequencer side, slave = program counter / top-level side.
interface pc_sequencer_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    PC;
    logic               halt;
    logic [INSTR_W-1:0] instr;
    logic               zero_flag;
    logic               pc_init;
    logic               branch_en;
    logic               jump_en;
    logic               done;
    logic               timeout;
    logic               halt_op;
    logic [PC_W-1:0]    final_pc;
    logic [15:0]        cycle_count;

    modport master (
        input  start, PC, halt, instr, zero_flag,
        output pc_init, branch_en, jump_en, done, timeout, halt_op, final_pc, cycle_count
    );

    modport slave (
        output start, PC, halt, instr, zero_flag,
        input  pc_init, branch_en, jump_en, done, timeout, halt_op, final_pc, cycle_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-run sequencer (IDLE/BOOT/RUN/DONE) that drives the program counter's init/branch/jump.
// pc_init and status are registered; branch_en/jump_en are same-cycle decodes of instr in RUN.
module pc_sequencer #(
    parameter int PC_W        = 10,
    parameter int INSTR_W     = 9,
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_CYCLES  = 1024
) (
    input  logic          CLK,
    input  logic          init,
    pc_sequencer_if.master bus
);
    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [15:0]       WDOG_LAST = 16'(MAX_CYCLES - 1);
    localparam logic [2:0]        OP_BEQZ   = 3'b110;
    localparam logic [2:0]        OP_JMPB   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOOT,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [BOOT_W-1:0] boot_cnt_q;
    logic [15:0]       cycle_cnt_q;
    logic [15:0]       cycle_cnt_d;
    logic [PC_W-1:0]   final_pc_q;
    logic              timeout_q;
    logic              halt_op_q;

    logic [2:0] opcode;
    logic       halt_instr;
    logic       wdog_hit;
    logic       run_exit;
    logic       in_run;

    always_comb begin
        opcode      = bus.instr[INSTR_W-1 -: 3];
        halt_instr  = (bus.instr == '0);
        wdog_hit    = (cycle_cnt_q == WDOG_LAST);
        run_exit    = bus.halt | halt_instr | wdog_hit;
        in_run      = (state_q == S_RUN);
        cycle_cnt_d = (cycle_cnt_q == 16'hFFFF) ? cycle_cnt_q : cycle_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            state_q     <= S_IDLE;
            boot_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            final_pc_q  <= '0;
            timeout_q   <= 1'b0;
            halt_op_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q     <= S_BOOT;
                        boot_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                        halt_op_q   <= 1'b0;
                    end
                end
                S_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (run_exit) begin
                        state_q    <= S_DONE;
                        final_pc_q <= bus.PC;
                        // A PC-side halt ends the run with neither cause flag set.
                        if (!bus.halt) begin
                            if (halt_instr) begin
                                halt_op_q <= 1'b1;
                            end else begin
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.start) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.pc_init     = (state_q == S_IDLE) || (state_q == S_BOOT);
    assign bus.branch_en   = in_run && !run_exit && (opcode == OP_BEQZ) && bus.zero_flag;
    assign bus.jump_en     = in_run && !run_exit && (opcode == OP_JMPB);
    assign bus.done        = (state_q == S_DONE);
    assign bus.timeout     = timeout_q;
    assign bus.halt_op     = halt_op_q;
    assign bus.final_pc    = final_pc_q;
    assign bus.cycle_count = cycle_cnt_q;

    a_branch_jump_exclusive: assert property (@(posedge CLK) !(bus.branch_en && bus.jump_en));
    a_cause_exclusive:       assert property (@(posedge CLK) !(timeout_q && halt_op_q));

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side partner of the program counter: drives the PC's `init`, `branch_en` and `jump_en` inputs, and consumes its `PC` and `halt` outputs.
- Decodes the instruction fetched at the current PC and decides branch/jump each cycle.
- Sequences a program run: idle, boot, run, done.
- Reports completion, final PC, cycle count and termination cause to the top level and testbench.

Parameters:
- PC_W, 10, width of PC.
- INSTR_W, 9, width of the instruction word.
- BOOT_CYCLES, 2, cycles pc_init is held in BOOT (minimum 1).
- MAX_CYCLES, 1024, watchdog limit on RUN cycles (minimum 2, at most 65535).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- init  in  1  synchronous active-high reset.
- start  in  1  level request to run a program.
- PC  in  PC_W  current PC from the program counter.
- halt  in  1  halt/trap flag from the program counter.
- instr  in  INSTR_W  instruction at PC; combinational ROM read.
- zero_flag  in  1  ALU zero flag for the current instruction.
- pc_init  out  1  drives the program counter's init.
- branch_en  out  1  drives the program counter's branch_en.
- jump_en  out  1  drives the program counter's jump_en.
- done  out  1  run finished; held until start drops.
- timeout  out  1  run ended by watchdog.
- halt_op  out  1  run ended by a HALT instruction.
- final_pc  out  PC_W  PC captured when entering DONE.
- cycle_count  out  16  RUN cycles elapsed in the current/last run.

Behaviour:
- Reset (init=1 at posedge):
  - state=IDLE, boot counter=0, cycle_count=0, final_pc=0, timeout=0, halt_op=0.
  - Reset overrides all other inputs in any state, including mid-RUN.
- States: IDLE, BOOT, RUN, DONE.
- pc_init is combinational from state: 1 in IDLE and BOOT, 0 in RUN and DONE. The PC is therefore frozen at 0 until RUN.
- IDLE:
  - start=1 -> BOOT.
  - Entering BOOT clears cycle_count, boot counter, timeout and halt_op.
- BOOT:
  - Stays exactly BOOT_CYCLES cycles, then -> RUN.
  - start is ignored while in BOOT.
- RUN: one instruction per cycle; priority order, highest first:
  - 1. halt=1 -> DONE; capture final_pc=PC.
  - 2. instr == 0 (HALT opcode) -> DONE; halt_op=1; capture final_pc=PC.
  - 3. cycle_count == MAX_CYCLES-1 -> DONE; timeout=1; capture final_pc=PC.
  - 4. Otherwise decode opcode = instr[INSTR_W-1:INSTR_W-3]:
    - 3'b110 (BEQZ): branch_en = zero_flag.
    - 3'b111 (JMPB): jump_en = 1.
    - Any other opcode: both 0.
- branch_en and jump_en are combinational (Mealy); the program counter samples them at the same posedge.
  - Both are 0 outside RUN and on any cycle where priorities 1–3 fire.
  - They are never asserted together.
- cycle_count increments by 1 on every RUN cycle (including the exiting cycle), saturates at 16'hFFFF, and holds in DONE and IDLE.
- DONE:
  - done=1; final_pc, timeout, halt_op and cycle_count hold.
  - start=0 -> IDLE, where done=0.
  - start held high keeps DONE; no automatic rerun.
- A halt already high on the first RUN cycle (e.g. sticky from a prior run) ends the run immediately with cycle_count=1.
- Only one of timeout and halt_op can be 1. Both 0 with done=1 means the PC's halt ended the run.

Test Plan:
- Reset, start=1, instr=9'h040 (non-branch), halt=0 -> pc_init=1 for exactly 2 cycles after leaving IDLE. Then branch_en=jump_en=0 and cycle_count counts 1,2,3…
- In RUN, instr=9'b110_000_101 with zero_flag=1 -> branch_en=1 that cycle. Same with zero_flag=0 -> branch_en=0. instr=9'b111_000_000 -> jump_en=1, branch_en=0.
- In RUN with PC=10'd37, instr=0 -> next cycle done=1, halt_op=1, final_pc=37, branch_en=jump_en=0.
- MAX_CYCLES=8, never halt -> done=1, timeout=1, cycle_count=8 after 8 RUN cycles. Drop start -> IDLE with done=0. Restart -> timeout cleared, cycle_count=0 in BOOT.
- halt=1 in RUN together with instr=JMPB -> jump_en=0, DONE, halt_op=0, timeout=0.
- init=1 mid-RUN with branch pending -> next cycle IDLE, pc_init=1, all status outputs 0.
